// File: rtl/mul_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arb_if
// Description : Request/response bundle between NREQ requesters and the
//               shared multiplier arbiter.
//               master : requester side (drives requests, accepts results)
//               slave  : arbiter side (grants requests, returns results)
//   req_valid / req_ready : per-requester handshake (ready is one-hot or 0)
//   req_a / req_b         : packed operands, requester i at [i*W +: W]
//   req_a_uns             : 1 = operand A is unsigned
//   rsp_valid / rsp_ready : result handshake
//   rsp_id / rsp_p        : requester index and signed 2W-bit product
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
) ();
  localparam int c_IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_a_uns;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [c_IDW-1:0]  rsp_id;
  logic [2*W-1:0]    rsp_p;

  modport master (
    output req_valid, req_a, req_b, req_a_uns, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, req_a_uns, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface
`default_nettype wire

// File: rtl/mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arb
// Description : Round-robin arbiter sharing one LAT-stage signed multiplier
//               among NREQ requesters. Operand A is sign- or zero-extended
//               per request; operand B is always signed. Results are tagged
//               with the requester index.
// Ports       : clk, rst (synchronous, active high)
//               bus       : mul_share_arb_if.slave (requests and results)
//               stall_cnt : cycles with rsp_valid && !rsp_ready (saturating)
//               grant_cnt : per-requester 16-bit handshake counters
//               stall_cnt/grant_cnt exist only when MUL_ARB_STATS_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mul_share_arb_if.slave     bus
`ifdef MUL_ARB_STATS_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);
  localparam int c_IDW = $clog2(NREQ);

  // Pipeline state; index LAT-1 is the output stage.
  logic             r_vld [LAT];
  logic [c_IDW-1:0] r_id  [LAT];
  logic [2*W-1:0]   r_p   [LAT];
  logic [c_IDW-1:0] r_ptr;

  logic             w_adv;
  logic             w_gnt_vld;
  logic [c_IDW-1:0] w_gnt_id;
  logic [W-1:0]     w_a;
  logic [W-1:0]     w_b;
  logic             w_uns;
  int               w_idx;
  logic signed [W:0]     w_ax;
  logic signed [W:0]     w_bx;
  logic signed [2*W+1:0] w_full;

  // Pipeline only stalls when a result is held on the output.
  assign w_adv = !(r_vld[LAT-1] && !bus.rsp_ready);

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_a       = '0;
    w_b       = '0;
    w_uns     = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_gnt_vld && bus.req_valid[w_idx] && w_adv && !rst) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = c_IDW'(w_idx);
        w_a       = bus.req_a[w_idx*W +: W];
        w_b       = bus.req_b[w_idx*W +: W];
        w_uns     = bus.req_a_uns[w_idx];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (w_gnt_vld) bus.req_ready[w_gnt_id] = 1'b1;
  end

  // W+1-bit extension keeps the product exact; the top two bits are
  // redundant and dropped.
  assign w_ax   = {(!w_uns && w_a[W-1]), w_a};
  assign w_bx   = {w_b[W-1], w_b};
  assign w_full = w_ax * w_bx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_vld[s] <= 1'b0;
        r_id[s]  <= '0;
        r_p[s]   <= '0;
      end
    end else if (w_adv) begin
      if (w_gnt_vld)
        r_ptr <= (w_gnt_id == c_IDW'(NREQ-1)) ? '0 : w_gnt_id + c_IDW'(1);
      r_vld[0] <= w_gnt_vld;
      r_id[0]  <= w_gnt_id;
      r_p[0]   <= w_gnt_vld ? w_full[2*W-1:0] : '0;
      for (int s = 1; s < LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
        r_p[s]   <= r_p[s-1];
      end
    end
  end

  assign bus.rsp_valid = r_vld[LAT-1];
  assign bus.rsp_id    = r_id[LAT-1];
  assign bus.rsp_p     = r_p[LAT-1];

`ifdef MUL_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (r_vld[LAT-1] && !bus.rsp_ready && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign stall_cnt = r_stall_cnt;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant_cnt
    logic [15:0] r_gcnt;
    always_ff @(posedge clk) begin
      if (rst)
        r_gcnt <= '0;
      else if (bus.req_valid[gi] && bus.req_ready[gi] && r_gcnt != 16'hFFFF)
        r_gcnt <= r_gcnt + 16'd1;
    end
    assign grant_cnt[gi*16 +: 16] = r_gcnt;
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_arb
// Description : Directed self-checking bench for mul_share_arb
//               (NREQ=4, W=8, LAT=2). Stats checks are built when
//               MUL_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_arb;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mul_share_arb_if #(.NREQ(4), .W(8)) bus ();

`ifdef MUL_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [63:0] grant_cnt;
`endif

  mul_share_arb #(.NREQ(4), .W(8), .LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MUL_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b, input logic uns);
    bus.req_a[id*8 +: 8] = a;
    bus.req_b[id*8 +: 8] = b;
    bus.req_a_uns[id]    = uns;
  endtask

  // Single isolated request; result expected exactly two edges later.
  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b,
                      input logic uns, input logic [15:0] exp);
    logic [3:0] one;
    one = 4'b0001 << id;
    set_ops(id, a, b, uns);
    bus.req_valid = one;
    #1;
    chk("send_grant", 32'(bus.req_ready), 32'(one));
    step();
    bus.req_valid = '0;
    chk("send_mid_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("send_valid", 32'(bus.rsp_valid), 32'd1);
    chk("send_id", 32'(bus.rsp_id), 32'(id));
    chk("send_p", 32'(bus.rsp_p), 32'(exp));
  endtask

  initial begin
    logic [1:0] eid;
    rst = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a_uns = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    // Reset state, with a request pending that must not be granted.
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_p", 32'(bus.rsp_p), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;

    // Signedness cases; first one is also the first request after reset.
    send(0, 8'h02, 8'hFF, 1'b1, 16'hFFFE);
    send(2, 8'hFF, 8'h80, 1'b1, 16'h8080);
    send(2, 8'hFF, 8'h80, 1'b0, 16'h0080);
    send(3, 8'hFF, 8'hFF, 1'b0, 16'h0001);
    step();
    chk("idle_bubble", 32'(bus.rsp_valid), 32'd0);

    // Round robin with all requesters active; ptr is back at 0 here.
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'h02, 1'b0);
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) chk("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        eid = 2'((k - 2) % 4);
        chk("rr_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rr_id", 32'(bus.rsp_id), 32'(eid));
        chk("rr_p", 32'(bus.rsp_p), 32'(2 * (eid + 1)));
      end
      step();
    end
    chk("rr_drained", 32'(bus.rsp_valid), 32'd0);

    // Output stall with two results in flight.
    set_ops(0, 8'h10, 8'h03, 1'b0);
    set_ops(1, 8'h80, 8'h02, 1'b1);
    bus.req_valid = 4'b0011;
    #1;
    chk("st_grant0", 32'(bus.req_ready), 32'b0001);
    step();
    chk("st_grant1", 32'(bus.req_ready), 32'b0010);
    step();
    set_ops(0, 8'h05, 8'hFD, 1'b0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("st_hold_id", 32'(bus.rsp_id), 32'd0);
      chk("st_hold_p", 32'(bus.rsp_p), 32'h0030);
      chk("st_no_grant", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("st_accept_grant", 32'(bus.req_ready), 32'b0001);
    chk("st_out0_p", 32'(bus.rsp_p), 32'h0030);
    step();
    bus.req_valid = '0;
    chk("st_out1_valid", 32'(bus.rsp_valid), 32'd1);
    chk("st_out1_id", 32'(bus.rsp_id), 32'd1);
    chk("st_out1_p", 32'(bus.rsp_p), 32'h0100);
    step();
    chk("st_out2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("st_out2_id", 32'(bus.rsp_id), 32'd0);
    chk("st_out2_p", 32'(bus.rsp_p), 32'hFFF1);
    step();
    chk("st_empty", 32'(bus.rsp_valid), 32'd0);

    // Reset mid-flight; ptr is 1, so 2 then 3 are granted.
    set_ops(2, 8'h03, 8'h03, 1'b0);
    set_ops(3, 8'h04, 8'h04, 1'b0);
    bus.req_valid = 4'b1100;
    #1;
    chk("rs_grant2", 32'(bus.req_ready), 32'b0100);
    step();
    chk("rs_grant3", 32'(bus.req_ready), 32'b1000);
    step();
    chk("rs_inflight", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    chk("rs_ready_in_rst", 32'(bus.req_ready), 32'd0);
    step();
    chk("rs_flushed", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    set_ops(1, 8'hF9, 8'h07, 1'b1);
    #1;
    chk("rs_first_grant", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    chk("rs_no_stale", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("rs_new_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rs_new_id", 32'(bus.rsp_id), 32'd1);
    chk("rs_new_p", 32'(bus.rsp_p), 32'h06CF);
    step();
    chk("rs_after", 32'(bus.rsp_valid), 32'd0);

`ifdef MUL_ARB_STATS_EN
    // Counters were cleared by the reset above; requester 1 has one grant.
    chk("sx_stall_zero", 32'(stall_cnt), 32'd0);
    send(1, 8'h01, 8'h01, 1'b0, 16'h0001);
    send(1, 8'h02, 8'h01, 1'b0, 16'h0002);
    step();
    set_ops(0, 8'h01, 8'h01, 1'b0);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = '0;
    step();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("sx_stall5", 32'(stall_cnt), 32'd5);
    chk("sx_grant1", 32'(grant_cnt[16 +: 16]), 32'd3);
    chk("sx_grant0", 32'(grant_cnt[0 +: 16]), 32'd1);
    for (int k = 0; k < 70000; k++) @(posedge clk);
    #1;
    chk("sx_stall_sat", 32'(stall_cnt), 32'h0000FFFF);
    bus.rsp_ready = 1'b1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
